// File: rtl/mux21_arbiter_if.sv
// mux21_arbiter_if
//   Bundles the requester/consumer side of the shared 2:1 word mux.
//   master : producer/consumer side (drives req, in0, in1; sees grant, sel, out, outValid)
//   slave  : arbiter side (mux21_arbiter)
//   Signals:
//     req      [1:0]        per-requester request
//     in0/in1  [WIDTH-1:0]  data words from requester 0/1
//     grant    [1:0]        one-hot registered grant, 00 when idle
//     sel                   registered mux select, 1 = in1 routed
//     out      [WIDTH-1:0]  muxed data word
//     outValid              out carries owner data this cycle
interface mux21_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [1:0]       grant;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic             outValid;

    modport master (
        output req, in0, in1,
        input  grant, sel, out, outValid
    );

    modport slave (
        input  req, in0, in1,
        output grant, sel, out, outValid
    );
endinterface

// File: rtl/mux21_arbiter.sv
// mux21_arbiter
//   Round-robin arbiter sharing one 2:1 word mux between two requesters.
//   Each owner holds the mux for at most BURST consecutive cycles; on release
//   ownership passes straight to the other requester if it is waiting, else a
//   still-requesting owner is re-granted, else the block goes idle.
//   Ports:
//     CLK      system clock, rising edge
//     Reset_L  asynchronous active-low reset
//     bus      mux21_arbiter_if.slave (req, in0, in1 in; grant, sel, out, outValid out)
//   Parameters:
//     WIDTH  data word width
//     BURST  max consecutive owned cycles (1..7)
//     CNTW   burst counter width, must hold BURST-1
module mux21_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int CNTW  = 3
) (
    input  logic            CLK,
    input  logic            Reset_L,
    mux21_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } stateE;

    localparam logic [CNTW-1:0] BurstMax = CNTW'(BURST - 1);

    stateE           state, stateNext;
    logic [CNTW-1:0] cnt, cntNext;
    logic            last, lastNext;

    // Current owner index and request view from the owner's perspective.
    logic owner;
    logic ownReq;
    logic othReq;

    assign owner  = (state == OWN1);
    assign ownReq = bus.req[owner];
    assign othReq = bus.req[~owner];

    function automatic stateE ownState(input logic who);
        return who ? OWN1 : OWN0;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;   // makes requester 0 win the first contested grant
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            last  <= lastNext;
        end
    end

    // Next-state logic. cnt defaults to 0 so every state change and every
    // burst re-entry restarts the burst count; only "continue" increments it.
    always_comb begin
        stateNext = state;
        cntNext   = '0;
        lastNext  = last;
        case (state)
            IDLE: begin
                case (bus.req)
                    2'b01: begin
                        stateNext = OWN0;
                        lastNext  = 1'b0;
                    end
                    2'b10: begin
                        stateNext = OWN1;
                        lastNext  = 1'b1;
                    end
                    2'b11: begin
                        stateNext = ownState(~last);
                        lastNext  = ~last;
                    end
                    default: ;
                endcase
            end
            OWN0, OWN1: begin
                if (ownReq && (cnt < BurstMax)) begin
                    cntNext = cnt + CNTW'(1);
                end else if (othReq) begin
                    // hand over directly, no idle bubble
                    stateNext = ownState(~owner);
                    lastNext  = ~owner;
                end else if (ownReq) begin
                    // lone requester hit the burst limit: re-enter, never starve
                    stateNext = ownState(owner);
                    lastNext  = owner;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state; data path is purely combinational.
    logic [1:0] grantInt;
    logic       selInt;

    assign grantInt     = {state == OWN1, state == OWN0};
    assign selInt       = (state == OWN1);
    assign bus.grant    = grantInt;
    assign bus.sel      = selInt;
    assign bus.out      = selInt ? bus.in1 : bus.in0;
    assign bus.outValid = grantInt[selInt] & bus.req[selInt];

endmodule

// File: tb/tb_mux21_arbiter.sv
module tb_mux21_arbiter;

    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int CNTW  = 3;

    logic CLK;
    logic Reset_L;

    mux21_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux21_arbiter #(.WIDTH(WIDTH), .BURST(BURST), .CNTW(CNTW)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]       grant;
        logic             sel;
        logic [WIDTH-1:0] out;
        logic             outValid;
    } expT;

    expT expQ[$];
    int  errors = 0;
    int  checks = 0;

    // Reference model: who owns the mux, how many cycles it has held it in
    // the current burst, and who was granted most recently.
    int owner;     // -1 = nobody
    int held;
    int lastW;

    function automatic void modelReset();
        owner = -1;
        held  = 0;
        lastW = 1;
    endfunction

    function automatic void giveTo(input int who);
        owner = who;
        held  = 1;
        lastW = who;
    endfunction

    function automatic void modelStep(input logic [1:0] r);
        if (owner < 0) begin
            if (r == 2'b11)   giveTo(1 - lastW);
            else if (r[0])    giveTo(0);
            else if (r[1])    giveTo(1);
        end else if (r[owner] && held < BURST) begin
            held++;
        end else if (r[1 - owner]) begin
            giveTo(1 - owner);
        end else if (r[owner]) begin
            giveTo(owner);
        end else begin
            owner = -1;
            held  = 0;
        end
    endfunction

    function automatic expT modelOut(input logic [1:0] r, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        expT e;
        e.grant    = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e.sel      = (owner == 1);
        e.out      = e.sel ? b : a;
        e.outValid = (owner >= 0) && r[owner];
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, queue expectation, advance model at posedge.
    task automatic cycle(input logic [1:0] r, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        @(negedge CLK);
        bus.req = r;
        bus.in0 = a;
        bus.in1 = b;
        expQ.push_back(modelOut(r, a, b));
        @(posedge CLK);
        if (Reset_L) modelStep(r);
    endtask

    // Monitor: pops one expectation per cycle and compares all outputs.
    initial begin
        expT e;
        forever begin
            @(negedge CLK);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checks++;
                if (bus.grant !== e.grant) begin
                    errors++;
                    $display("FAIL grant @%0t: got %b want %b", $time, bus.grant, e.grant);
                end
                checks++;
                if (bus.sel !== e.sel) begin
                    errors++;
                    $display("FAIL sel @%0t: got %b want %b", $time, bus.sel, e.sel);
                end
                checks++;
                if (bus.out !== e.out) begin
                    errors++;
                    $display("FAIL out @%0t: got %h want %h", $time, bus.out, e.out);
                end
                checks++;
                if (bus.outValid !== e.outValid) begin
                    errors++;
                    $display("FAIL outValid @%0t: got %b want %b", $time, bus.outValid, e.outValid);
                end
            end
        end
    end

    initial begin
        modelReset();
        Reset_L = 1'b0;
        bus.req = 2'b00;
        bus.in0 = '0;
        bus.in1 = '0;

        // Reset held with both requesting: nothing granted.
        cycle(2'b11, 8'h11, 8'h22);
        cycle(2'b11, 8'h11, 8'h22);
        #2 Reset_L = 1'b1;
        // First contested grant goes to requester 0.
        cycle(2'b11, 8'h11, 8'h22);
        cycle(2'b11, 8'h11, 8'h22);

        // Idle return, then lone requester 1 across several bursts.
        cycle(2'b00, 8'h00, 8'hA5);
        cycle(2'b00, 8'h00, 8'hA5);
        for (int i = 0; i < 10; i++) cycle(2'b10, 8'h00, 8'hA5);

        // Fair sharing with constant contention.
        for (int i = 0; i < 12; i++) cycle(2'b11, 8'h11, 8'h22);

        // Early release: get OWN0, continue once, drop req[0] while req[1] waits.
        cycle(2'b00, 8'h33, 8'h44);
        cycle(2'b00, 8'h33, 8'h44);
        cycle(2'b01, 8'h33, 8'h44);
        cycle(2'b11, 8'h33, 8'h44);
        cycle(2'b10, 8'h33, 8'h44);
        cycle(2'b10, 8'h33, 8'h44);
        cycle(2'b10, 8'h33, 8'h44);

        // Owner drops with nobody else waiting, then new request from 0.
        cycle(2'b00, 8'h55, 8'h66);
        cycle(2'b01, 8'h55, 8'h66);
        cycle(2'b01, 8'h55, 8'h66);

        // Async reset mid-burst during OWN1.
        cycle(2'b00, 8'h77, 8'h88);
        cycle(2'b10, 8'h77, 8'h88);
        cycle(2'b10, 8'h77, 8'h88);
        #2 Reset_L = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 2'b00 || bus.sel !== 1'b0) begin
            errors++;
            $display("FAIL asyncReset: got grant=%b sel=%b want grant=00 sel=0", bus.grant, bus.sel);
        end
        modelReset();
        #1 Reset_L = 1'b1;
        cycle(2'b10, 8'h77, 8'h88);
        cycle(2'b10, 8'h77, 8'h88);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end

        @(negedge CLK);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux21_arbiter.md
Name: mux21_arbiter

Overview:
Round-robin arbiter that shares one 2:1 word multiplexer between two requesters. It drives the mux select and returns a one-hot grant to each requester. Each owner holds the mux for a bounded burst of cycles. It sits between two producer blocks and a single downstream consumer.

Parameters:
WIDTH, 8, data word width of each input and of out
BURST, 4, maximum consecutive cycles one requester may own the mux (legal range 1..7)
CNTW, 3, width of the burst counter (must hold BURST-1)

Ports:
CLK  input  1  system clock, rising edge
Reset_L  input  1  asynchronous, active-low reset
req  input  2  req[i]=1: requester i wants the mux
in0  input  WIDTH  data from requester 0
in1  input  WIDTH  data from requester 1
grant  output  2  one-hot registered grant; 2'b00 when idle
sel  output  1  registered mux select; 1 = in1 routed
out  output  WIDTH  sel ? in1 : in0 (combinational mux)
outValid  output  1  out carries owner data this cycle

Behaviour:
- Design has one clock. Reset is asynchronous, active-low (Reset_L). All registers use one clock domain.
- Reset values: state=IDLE, grant=2'b00, sel=0, cnt=0, last=1, outValid=0, out=in0.
- Reset asserted mid-burst clears all registers immediately, without waiting for CLK. The grant is lost.
- State machine has three states: IDLE, OWN0, OWN1. grant and sel are decoded from registered state: OWN0 gives 01/0, OWN1 gives 10/1, IDLE gives 00/0.
- last records the most recently granted requester. It updates on entry to OWNx.
- Transitions from IDLE:
  - req=00: stay in IDLE.
  - req=01: go to OWN0. req=10: go to OWN1.
  - req=11: grant the requester that is not last. After reset, requester 0 wins.
- OWNx, continue: req[x]=1 and cnt<BURST-1. Stay in OWNx, cnt+1.
- OWNx, release: req[x]=0, or cnt==BURST-1.
  - If the other requester is requesting, go directly to OWN(other) with cnt=0. No idle bubble.
  - Otherwise, if req[x] is still 1, re-enter OWNx with cnt=0. A lone requester is never starved by its own burst limit.
  - Otherwise, go to IDLE with cnt=0.
- cnt resets to 0 on every state change and on re-entry. It never exceeds BURST-1.
- Grant latency: a request first seen on edge N sets grant after edge N. Minimum req-to-grant is 1 cycle.
- outValid = grant[sel] & req[sel] (combinational). When the owner drops req, outValid falls the same cycle and grant falls one edge later.
- out follows in0/in1 combinationally through the registered sel. The block adds no data register.
- A requester may drop req while ungranted. Nothing is recorded.
- BURST=1 alternates ownership every cycle when both requesters are active.

Test Plan:
- Reset: hold Reset_L=0 with req=11 → grant=00, sel=0, outValid=0. Release, then after 1 edge → grant=01, out=in0.
- Single requester: req=10, in1=8'hA5 held 10 cycles → grant=10 after 1 edge and stays 10 continuously (burst re-entry). out=A5, outValid=1 throughout.
- Fair sharing: BURST=4, req=11 constant, in0=11, in1=22 → grant sequence 01×4, 10×4, 01×4. out alternates 11/22 in blocks of 4 with no idle cycle.
- Early release: OWN0 at cnt=1, drop req[0] with req[1]=1 → outValid=0 that cycle. grant=10 after next edge, cnt=0.
- Idle return: owner drops req with other req=0 → next edge grant=00, sel=0. New req=01 → grant=01 one edge later.
- Async reset mid-burst: assert Reset_L=0 between edges during OWN1 → grant=00, sel=0 immediately, before the next CLK edge.
